// File: rtl/gpio_input_conditioner.sv
// Purpose    : synchronize, debounce and edge-detect raw GPIO pads; latch sticky edge events and raise irq.
// Latency    : pad change before edge N -> db_out/rise_o/fall_o/evt_pending update after edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1.
// Backpressure: none; free-running per-bit pipeline, outputs are level/pulse, evt_pending held until cleared.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   pad_in       raw asynchronous pad levels
//   rise_en      per-bit: accepted rising edges set evt_pending
//   fall_en      per-bit: accepted falling edges set evt_pending
//   evt_clr      per-bit write-1-to-clear for evt_pending (a same-cycle new event wins)
//   db_out       debounced, synchronized level
//   rise_o       one-cycle pulse on db_out 0->1
//   fall_o       one-cycle pulse on db_out 1->0
//   evt_pending  sticky event flags
//   irq_o        OR of evt_pending
module gpio_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] evt_pending,
    output logic             irq_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] evt_set;

    // Plain shift chain: nothing but flops between the pad and the last stage.
    always_comb begin
        sync_d[0] = pad_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synchronized level disagrees with the
    // accepted level; any agreement restarts it, so short glitches vanish.
    always_comb begin
        db_d = db_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync_s[b] == db_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_MAX) begin
                db_d[b]  = sync_s[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
            end
        end
    end

    // Edges are taken from the next-state level so the pulses and the
    // pending set line up with the db_out update.
    always_comb begin
        rise_d  = db_d & ~db_q;
        fall_d  = ~db_d & db_q;
        evt_set = (rise_d & rise_en) | (fall_d & fall_en);
        pend_d  = evt_set | (pend_q & ~evt_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            pend_q <= pend_d;
        end
    end

    assign db_out      = db_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign evt_pending = pend_q;
    assign irq_o       = |pend_q;

endmodule
